tc_arbiter: RTL and testbench

- Round-robin scheduler that shares one bit-transition counter (TC: 10-bit Data in, 5-bit Count out) between N_REQ requesters.
- Accepts one word per valid/ready handshake and sequences the counter's clear and load.
- Waits a fixed counter latency, then returns the count tagged with the requester ID on a valid/ready response channel.
- Sits between client logic and the TC instance; it is the only driver of the TC inputs.

---
 rtl/tc_pkg.sv | 26 ++
 rtl/tc_rr_pick.sv | 32 +++
 rtl/tc_arbiter.sv | 108 ++++++++++
 tb/tb_tc_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types, constants and the golden transition-count function for the
// bit-transition counter arbiter.
package tc_pkg;

  localparam int TC_DATA_W = 10;
  localparam int TC_CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_WAIT,
    ST_RESP
  } tc_arb_state_t;

  // Number of adjacent bit pairs that differ within a word.
  function automatic logic [TC_CNT_W-1:0] tc_ref_count(input logic [TC_DATA_W-1:0] word);
    logic [TC_CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i + 1 < TC_DATA_W; i++) begin
      n = n + TC_CNT_W'(word[i] ^ word[i+1]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping around, returned as a one-hot grant plus its index.
module tc_rr_pick
  import tc_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             found
);

  int unsigned best;

  // The winner is the valid requester with the smallest distance above ptr.
  always_comb begin
    best  = N_REQ;
    idx   = '0;
    found = |valid;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (valid[i] && (((i + N_REQ - 32'(ptr)) % N_REQ) < best)) begin
        best = (i + N_REQ - 32'(ptr)) % N_REQ;
        idx  = IDW'(i);
      end
    end
    grant = found ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/tc_arbiter.sv
// Round-robin scheduler sharing one bit-transition counter between N_REQ
// requesters; sequences clear/load and returns the tagged count.
module tc_arbiter
  import tc_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = TC_DATA_W,
  parameter int CNT_W      = TC_CNT_W,
  parameter int TC_LAT     = 1,
  parameter int CLEAR_EACH = 1
) (
  input  logic                      CLK,
  input  logic                      Clear,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      rsp_err,
  output logic                      tc_clear_n,
  output logic                      tc_load,
  output logic [DATA_W-1:0]         tc_data,
  input  logic [CNT_W-1:0]          tc_count,
  output logic                      busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WCW = (TC_LAT > 1) ? $clog2(TC_LAT) : 1;

  tc_arb_state_t     state, state_nxt;
  logic [IDW-1:0]    ptr, win_id, pick_idx;
  logic [N_REQ-1:0]  pick_grant;
  logic              pick_found;
  logic              accept;
  logic [DATA_W-1:0] word, pick_word;
  logic [WCW-1:0]    wcnt;

  tc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDW'(i)) pick_word = req_data[i*DATA_W +: DATA_W];
    end
  end

  // The grant only ever selects a valid requester, so a grant is a handshake.
  assign accept    = (state == ST_IDLE) && !Clear && pick_found;
  assign req_ready = accept ? pick_grant : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = (CLEAR_EACH != 0) ? ST_CLR : ST_LOAD;
      ST_CLR:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_WAIT;
      ST_WAIT: if (wcnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_valid  = (state == ST_RESP);
  assign tc_load    = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign tc_clear_n = !Clear && (state != ST_CLR);
  assign tc_data    = word;
  assign rsp_id     = win_id;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win_id    <= '0;
      word      <= '0;
      wcnt      <= '0;
      rsp_count <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word   <= pick_word;
        win_id <= pick_idx;
      end
      if (state == ST_LOAD) begin
        wcnt <= WCW'(TC_LAT - 1);
      end else if (state == ST_WAIT && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (state == ST_WAIT && wcnt == '0) begin
        rsp_count <= tc_count;
        rsp_err   <= (32'(tc_count) > 32'(DATA_W - 1));
      end
      if (state == ST_RESP && rsp_ready) begin
        ptr <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tc_arbiter.sv
// Scoreboard bench for tc_arbiter: a transaction-level model predicts grants,
// timing and results; a monitor checks each response handshake.
module tb_tc_arbiter;
  import tc_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 10;
  localparam int CW  = 5;
  localparam int LAT = 1;
  localparam int IDW = 2;

  logic              CLK = 1'b0;
  logic              Clear;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [CW-1:0]     rsp_count;
  logic              rsp_err;
  logic              tc_clear_n, tc_load;
  logic [DW-1:0]     tc_data;
  logic [CW-1:0]     tc_count;
  logic              busy;

  tc_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW), .TC_LAT(LAT), .CLEAR_EACH(1)) dut (
    .CLK(CLK), .Clear(Clear), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_err(rsp_err),
    .tc_clear_n(tc_clear_n), .tc_load(tc_load), .tc_data(tc_data),
    .tc_count(tc_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Transition-counter stand-in with a one-cycle load latency.
  logic          force_en = 1'b0;
  logic [CW-1:0] force_val = '0;
  always @(posedge CLK) begin
    if (!tc_clear_n)  tc_count <= '0;
    else if (tc_load) tc_count <= force_en ? force_val : tc_ref_count(tc_data);
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   id_log[$];
  int   cnt_log[$];
  int   err_log[$];
  int   passed = 0;
  int   total  = 0;

  // model: 0 idle, 1 working (m_left cycles to go), 2 holding a response
  int          m_state = 0;
  int          m_left  = 0;
  int          m_ptr   = 0;
  int          m_id    = 0;
  int          n_acc   = 0;
  int          last_acc_id = -1;
  logic [DW-1:0] m_word = '0;
  bit          prev_clear = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v, input int p);
    logic [N-1:0] g;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) begin
        g = '0;
        g[j] = 1'b1;
        return g;
      end
    end
    return '0;
  endfunction

  // Check the current cycle against the model, then advance to the next cycle.
  task automatic tick();
    logic [N-1:0] eg;
    exp_t         e;
    int           idx;
    #1;
    if (Clear) begin
      chk("reset_clear_n", 32'(tc_clear_n), 32'(0));
      if (prev_clear) begin
        chk("reset_req_ready", 32'(req_ready), 32'(0));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
      end
      if (m_state != 0 && sb.size() > 0) void'(sb.pop_back());
      m_state = 0;
      m_ptr   = 0;
    end else begin
      case (m_state)
        0: begin
          eg = rr_expect(req_valid, m_ptr);
          chk("req_ready", 32'(req_ready), 32'(eg));
          chk("idle_busy", 32'(busy), 32'(0));
          chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
          chk("idle_tc_load", 32'(tc_load), 32'(0));
          chk("idle_clear_n", 32'(tc_clear_n), 32'(1));
          if (eg != '0) begin
            idx = 0;
            for (int k = 0; k < N; k++) if (eg[k]) idx = k;
            m_word = req_data[idx*DW +: DW];
            e.id   = IDW'(idx);
            e.cnt  = force_en ? force_val : tc_ref_count(m_word);
            e.err  = (32'(e.cnt) > 32'(DW - 1));
            sb.push_back(e);
            m_id = idx;
            last_acc_id = idx;
            n_acc++;
            m_state = 1;
            m_left  = 2 + LAT;
          end
        end
        1: begin
          chk("work_req_ready", 32'(req_ready), 32'(0));
          chk("work_busy", 32'(busy), 32'(1));
          chk("work_rsp_valid", 32'(rsp_valid), 32'(0));
          chk("clear_n_pulse", 32'(tc_clear_n), 32'(m_left != 2 + LAT));
          chk("load_pulse", 32'(tc_load), 32'(m_left == 1 + LAT));
          if (m_left <= 1 + LAT) chk("tc_data", 32'(tc_data), 32'(m_word));
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        default: begin
          chk("resp_rsp_valid", 32'(rsp_valid), 32'(1));
          chk("resp_busy", 32'(busy), 32'(1));
          chk("resp_req_ready", 32'(req_ready), 32'(0));
          chk("resp_tc_load", 32'(tc_load), 32'(0));
          if (rsp_ready) begin
            m_ptr   = (m_id + 1) % N;
            m_state = 0;
          end
        end
      endcase
    end
    prev_clear = Clear;
    @(negedge CLK);
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 40 && m_state != 0; t++) tick();
    chk("drain_timeout", 32'(m_state), 32'(0));
  endtask

  // Response monitor: pops the scoreboard on every handshake.
  bit             stall_prev = 1'b0;
  logic [IDW-1:0] s_id;
  logic [CW-1:0]  s_cnt;
  logic           s_err;
  exp_t           me;
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (!Clear && rsp_valid) begin
        if (stall_prev) begin
          chk("stall_rsp_id", 32'(rsp_id), 32'(s_id));
          chk("stall_rsp_count", 32'(rsp_count), 32'(s_cnt));
          chk("stall_rsp_err", 32'(rsp_err), 32'(s_err));
        end
        if (rsp_ready) begin
          stall_prev = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(1), 32'(0));
          end else begin
            me = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(me.id));
            chk("rsp_count", 32'(rsp_count), 32'(me.cnt));
            chk("rsp_err", 32'(rsp_err), 32'(me.err));
          end
          id_log.push_back(int'(rsp_id));
          cnt_log.push_back(int'(rsp_count));
          err_log.push_back(int'(rsp_err));
        end else begin
          stall_prev = 1'b1;
          s_id  = rsp_id;
          s_cnt = rsp_count;
          s_err = rsp_err;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  int exp_ids[5] = '{0, 1, 2, 3, 0};
  int exp_cnt[5] = '{0, 9, 0, 1, 0};
  int base, start, lsz;

  initial begin
    Clear     = 1'b1;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset held two cycles with every requester asking
    tick();
    tick();
    Clear = 1'b0;

    // All four held valid: grants rotate 0,1,2,3,0
    req_data = {10'h001, 10'h000, 10'h2AA, 10'h3FF};
    base  = id_log.size();
    start = n_acc;
    for (int t = 0; t < 100 && n_acc < start + 5; t++) tick();
    drain();
    chk("rr_log_size", 32'(id_log.size() - base), 32'(5));
    if (id_log.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", 32'(id_log[base+k]), 32'(exp_ids[k]));
        chk("rr_count", 32'(cnt_log[base+k]), 32'(exp_cnt[k]));
      end
    end

    // Single request from requester 2
    req_data = '0;
    req_data[2*DW +: DW] = 10'h005;
    req_valid = 4'b0100;
    start = n_acc;
    for (int t = 0; t < 20 && n_acc == start; t++) tick();
    drain();
    lsz = id_log.size();
    if (lsz > 0) begin
      chk("single_id", 32'(id_log[lsz-1]), 32'(2));
      chk("single_count", 32'(cnt_log[lsz-1]), 32'(3));
      chk("single_err", 32'(err_log[lsz-1]), 32'(0));
    end

    // Backpressure: response held for 10 cycles with others waiting
    rsp_ready = 1'b0;
    req_valid = '1;
    req_data  = 40'({$urandom(), $urandom()});
    for (int t = 0; t < 20 && m_state != 2; t++) tick();
    chk("bp_reach_resp", 32'(m_state), 32'(2));
    repeat (10) tick();
    rsp_ready = 1'b1;
    tick();
    tick();
    drain();

    // Impossible count from the counter flags an error
    force_en  = 1'b1;
    force_val = 5'd12;
    req_valid = 4'b0010;
    req_data  = 40'({$urandom(), $urandom()});
    start = n_acc;
    for (int t = 0; t < 20 && n_acc == start; t++) tick();
    drain();
    force_en = 1'b0;
    lsz = id_log.size();
    if (lsz > 0) begin
      chk("err_count", 32'(cnt_log[lsz-1]), 32'(12));
      chk("err_flag", 32'(err_log[lsz-1]), 32'(1));
    end

    // Abort: reset lands while waiting on the counter
    req_valid = 4'b1000;
    start = n_acc;
    for (int t = 0; t < 20 && n_acc == start; t++) tick();
    req_valid = '0;
    for (int t = 0; t < 20 && !(m_state == 1 && m_left == 1); t++) tick();
    chk("abort_reach_wait", 32'(m_state == 1 && m_left == 1), 32'(1));
    lsz = id_log.size();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    repeat (8) tick();
    chk("abort_no_rsp", 32'(id_log.size()), 32'(lsz));
    req_valid = '1;
    start = n_acc;
    for (int t = 0; t < 20 && n_acc == start; t++) tick();
    chk("abort_ptr_restart", 32'(last_acc_id), 32'(0));
    drain();

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      req_valid = N'($urandom());
      req_data  = 40'({$urandom(), $urandom()});
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    repeat (2) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
